uart_byte_fifo: RTL and testbench
=================================

Name: uart_byte_fifo

Overview:
- Receive-side buffer stage between the UART receiver and the UART transmitter, all in the 25 MHz PLL clock domain.
- Captures each byte completed by the receiver into a circular FIFO.
- Drains the FIFO to the transmitter one byte at a time with a start/busy handshake.
- Lets back-to-back received bytes survive while the transmitter is still sending.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- AW, 4, pointer width; equals log2(DEPTH).
- TX_WAIT_MAX, 1023, cycles to wait for tx_busy to rise after tx_start before the byte is abandoned.

Ports:
- clk  input  1  system clock (25 MHz PLL output).
- rst  input  1  asynchronous, active-low reset.
- rx_intr  input  1  high while the receiver is assembling a byte; its falling edge marks rx_data valid.
- rx_data  input  8  received byte; stable for at least one cycle after the rx_intr falling edge.
- tx_busy  input  1  high while the transmitter is shifting a byte out.
- ovf_clr  input  1  one-cycle pulse that clears overflow and tx_drop.
- tx_start  output  1  one-cycle pulse requesting transmission of tx_data.
- tx_data  output  8  byte to transmit; held from tx_start until the next FIFO read.
- fifo_count  output  AW+1  number of stored bytes, 0..DEPTH.
- empty  output  1  fifo_count == 0.
- full  output  1  fifo_count == DEPTH.
- overflow  output  1  sticky; a received byte was dropped because the FIFO was full.
- tx_drop  output  1  sticky; a byte was abandoned on tx_busy timeout.

Behaviour:
- Reset (rst=0, async): state IDLE; wr_ptr=rd_ptr=0; fifo_count=0; empty=1; full=0; tx_start=0; tx_data=0x00; overflow=0; tx_drop=0; rx_intr_d=0; wait timer=0.
- Reset mid-operation: FIFO contents are discarded and tx_start drops immediately. Memory array contents need not be reset.
- Write detect: rx_intr_d registers rx_intr every cycle. A write event is rx_intr_d=1 && rx_intr=0. Because rx_intr_d resets to 0, no event is generated by a low rx_intr out of reset.
- Write accept: accepted if fifo_count<DEPTH, or if a read occurs in the same cycle. On accept: mem[wr_ptr]<=rx_data, wr_ptr increments mod DEPTH.
- Write reject: otherwise the byte is dropped and overflow<=1.
- Read: occurs only in IDLE when empty=0 and tx_busy=0. On read: tx_data<=mem[rd_ptr], rd_ptr increments mod DEPTH, next state START.
- fifo_count: +1 on write only, -1 on read only, unchanged on simultaneous write and read. empty and full are registered alongside it.
- Write into an empty FIFO: no same-cycle read is possible (read is gated by the registered empty).
- Pointer wrap: natural AW-bit rollover. fifo_count distinguishes full from empty.
- FSM:
  - IDLE: read condition true -> START; otherwise stay.
  - START: tx_start=1 for exactly this cycle; timer cleared -> WAIT_BUSY.
  - WAIT_BUSY: tx_busy=1 -> WAIT_DONE. Otherwise timer increments; when timer==TX_WAIT_MAX, tx_drop<=1 -> IDLE (the byte is lost, not re-queued).
  - WAIT_DONE: tx_busy=0 -> IDLE.
- Latency: write at clock edge E (first edge sampling rx_intr low) -> empty=0 after E -> read at E+1 -> tx_start high during the cycle after E+1.
- Throughput: one byte per transmitter frame, plus 2 cycles of overhead (IDLE, START).
- ovf_clr=1 clears overflow and tx_drop. If a new overflow or timeout occurs in the same cycle, set wins.
- tx_start is never asserted while tx_busy was high in the previous cycle, so bytes never overlap.

Test Plan:
- Single byte: reset, send 0xA5 via rx_intr pulse -> fifo_count 0->1->0; tx_start pulses once with tx_data=0xA5; the rx_intr falling edge is at E and tx_start is high for the cycle following E+1; model tx_busy high for 50 cycles -> FSM returns to IDLE, empty=1.
- Burst: 5 bytes 0x01..0x05 while tx_busy is held high -> fifo_count=5; then model transmission -> tx_data sequence is 0x01..0x05 in order, 5 tx_start pulses, each after tx_busy falls.
- Full/overflow: with tx_busy held high, write DEPTH+1 bytes 0x10..0x20 -> full=1 at 16, byte 0x20 dropped, overflow=1; drain -> output 0x10..0x1F only; ovf_clr pulse -> overflow=0.
- Simultaneous write/read at full: full FIFO, release tx_busy so a read coincides with a write event -> fifo_count stays 16, the new byte is accepted, overflow stays 0.
- Timeout: tx_busy tied low, send 0x3C -> tx_start pulses; after 1023 cycles tx_drop=1, FSM in IDLE; next byte 0x3D triggers a new tx_start.
- Async reset mid-drain: assert rst low during WAIT_DONE with 3 bytes queued -> outputs take reset values immediately; after release, no tx_start occurs without new rx input.

Source files
------------

// File: rtl/uart_byte_fifo.sv
// Byte FIFO from the UART receiver to the transmitter. Bytes are taken on the rx_intr falling edge.
// tx_start comes 2 cycles after a write. A full FIFO drops the byte and sets overflow. A tx_busy timeout drops the byte and sets tx_drop.
module uart_byte_fifo #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int TX_WAIT_MAX = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_intr,
  input  logic [7:0]    rx_data,
  input  logic          tx_busy,
  input  logic          ovf_clr,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  output logic [AW:0]   fifo_count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          tx_drop
);

  localparam int TW = $clog2(TX_WAIT_MAX + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, full_q;
  logic          overflow_q, overflow_d;
  logic          tx_drop_q, tx_drop_d;
  logic          rx_intr_q;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          wr_evt, wr_en, rd_en, drop_set;
  logic [7:0]    mem [DEPTH];

  assign wr_evt = rx_intr_q & ~rx_intr;
  assign rd_en  = (state_q == IDLE) & ~empty_q & ~tx_busy;
  // A full FIFO still takes the byte when a read frees a slot on the same edge.
  assign wr_en  = wr_evt & (~full_q | rd_en);

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    drop_set = 1'b0;
    case (state_q)
      IDLE:      if (rd_en) state_d = START;
      START: begin
        timer_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TW'(TX_WAIT_MAX)) begin
          drop_set = 1'b1;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign overflow_d = (wr_evt & ~wr_en) | (overflow_q & ~ovf_clr);
  assign tx_drop_d  = drop_set | (tx_drop_q & ~ovf_clr);
  assign tx_data_d  = rd_en ? mem[rd_ptr_q] : tx_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      tx_drop_q  <= 1'b0;
      rx_intr_q  <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == (AW+1)'(DEPTH));
      overflow_q <= overflow_d;
      tx_drop_q  <= tx_drop_d;
      rx_intr_q  <= rx_intr;
      tx_data_q  <= tx_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= rx_data;
  end

  assign tx_start   = (state_q == START);
  assign tx_data    = tx_data_q;
  assign fifo_count = count_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign overflow   = overflow_q;
  assign tx_drop    = tx_drop_q;

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Directed bench for uart_byte_fifo with a transmitter model and an in-order byte scoreboard.
module tb_uart_byte_fifo;

  logic       clk = 1'b0;
  logic       rst, rx_intr, tx_busy, ovf_clr;
  logic [7:0] rx_data;
  logic       tx_start, empty, full, overflow, tx_drop;
  logic [7:0] tx_data;
  logic [4:0] fifo_count;

  logic       hold_busy  = 1'b0;
  logic       model_busy = 1'b0;
  logic       auto_tx    = 1'b0;
  int         busy_len   = 20;
  logic       prev_busy  = 1'b0;
  int         total = 0, bad = 0, starts = 0;
  logic [7:0] sb [$];

  assign tx_busy = hold_busy | model_busy;

  uart_byte_fifo #(.DEPTH(16), .AW(4), .TX_WAIT_MAX(1023)) dut (
    .clk(clk), .rst(rst), .rx_intr(rx_intr), .rx_data(rx_data),
    .tx_busy(tx_busy), .ovf_clr(ovf_clr), .tx_start(tx_start),
    .tx_data(tx_data), .fifo_count(fifo_count), .empty(empty),
    .full(full), .overflow(overflow), .tx_drop(tx_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_intr = 1'b1;
    tick();
    tick();
    rx_intr = 1'b0;
    tick();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || !empty) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 1);
    repeat (busy_len + 10) tick();
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!tx_start && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(tx_start), 1);
  endtask

  // Scoreboard side: every tx_start must carry the oldest expected byte.
  always @(negedge clk) begin
    if (rst && tx_start) begin
      starts++;
      chk("start_after_busy_low", 32'(prev_busy), 0);
      chk("start_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) chk("tx_data_order", 32'(tx_data), 32'(sb.pop_front()));
    end
    prev_busy = tx_busy;
  end

  // Transmitter model: busy for busy_len cycles after each tx_start.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (auto_tx && tx_start) begin
        model_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #2;
        model_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int n;
    rst = 1'b0; rx_intr = 1'b0; rx_data = 8'h00; ovf_clr = 1'b0;
    tick();
    tick();
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_tx_drop", 32'(tx_drop), 0);
    rst = 1'b1;
    tick();
    tick();
    chk("post_rst_empty", 32'(empty), 1);

    // Single byte with latency check
    auto_tx = 1'b1; busy_len = 50; s0 = starts;
    sb.push_back(8'hA5);
    rx_data = 8'hA5; rx_intr = 1'b1;
    tick();
    tick();
    chk("single_count0", 32'(fifo_count), 0);
    rx_intr = 1'b0;
    tick();
    chk("single_count1", 32'(fifo_count), 1);
    chk("single_nempty", 32'(empty), 0);
    chk("single_nostart_E", 32'(tx_start), 0);
    tick();
    chk("single_start_E1", 32'(tx_start), 1);
    chk("single_data", 32'(tx_data), 32'h A5);
    chk("single_count_back0", 32'(fifo_count), 0);
    repeat (60) tick();
    chk("single_one_start", 32'(starts - s0), 1);
    chk("single_empty_end", 32'(empty), 1);

    // Burst of five while the transmitter is busy
    hold_busy = 1'b1; busy_len = 20; s0 = starts;
    for (int i = 1; i <= 5; i++) begin
      sb.push_back(8'(i));
      send(8'(i));
    end
    chk("burst_count5", 32'(fifo_count), 5);
    chk("burst_no_start", 32'(starts - s0), 0);
    hold_busy = 1'b0;
    drain(1000);
    chk("burst_starts", 32'(starts - s0), 5);

    // Fill past DEPTH: the 17th byte is dropped
    hold_busy = 1'b1; s0 = starts;
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) sb.push_back(8'(8'h10 + i));
      send(8'(8'h10 + i));
      if (i == 15) begin
        chk("ovf_full_at16", 32'(full), 1);
        chk("ovf_not_yet", 32'(overflow), 0);
      end
    end
    chk("ovf_count16", 32'(fifo_count), 16);
    chk("ovf_set", 32'(overflow), 1);
    hold_busy = 1'b0;
    drain(2000);
    chk("ovf_starts16", 32'(starts - s0), 16);
    chk("ovf_sticky", 32'(overflow), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);

    // Write event coinciding with a read on a full FIFO
    hold_busy = 1'b1; s0 = starts;
    for (int i = 0; i < 16; i++) begin
      sb.push_back(8'(8'h40 + i));
      send(8'(8'h40 + i));
    end
    chk("sim_full", 32'(full), 1);
    rx_data = 8'h50; rx_intr = 1'b1;
    tick();
    tick();
    rx_intr = 1'b0; hold_busy = 1'b0;
    sb.push_back(8'h50);
    tick();
    chk("sim_count16", 32'(fifo_count), 16);
    chk("sim_full_kept", 32'(full), 1);
    chk("sim_no_ovf", 32'(overflow), 0);
    chk("sim_start", 32'(tx_start), 1);
    drain(2000);
    chk("sim_starts17", 32'(starts - s0), 17);

    // tx_busy never rises: byte abandoned after the wait limit
    auto_tx = 1'b0; s0 = starts;
    sb.push_back(8'h3C);
    send(8'h3C);
    wait_start("to_start1");
    repeat (1000) tick();
    chk("to_not_yet", 32'(tx_drop), 0);
    n = 0;
    while (!tx_drop && n < 50) begin
      tick();
      n++;
    end
    chk("to_drop_set", 32'(tx_drop), 1);
    chk("to_empty", 32'(empty), 1);
    sb.push_back(8'h3D);
    send(8'h3D);
    wait_start("to_start2");
    tick();
    chk("to_starts2", 32'(starts - s0), 2);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("to_drop_cleared", 32'(tx_drop), 0);
    repeat (1100) tick();
    chk("to_drop_again", 32'(tx_drop), 1);

    // Async reset while a byte is in flight and three are queued
    auto_tx = 1'b1; busy_len = 50; hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) send(8'(8'h61 + i));
    sb.push_back(8'h61);
    hold_busy = 1'b0;
    wait_start("rst_drain_start");
    repeat (10) tick();
    chk("rst_mid_count3", 32'(fifo_count), 3);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", 32'(fifo_count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_tx_start", 32'(tx_start), 0);
    chk("arst_tx_data", 32'(tx_data), 0);
    chk("arst_tx_drop", 32'(tx_drop), 0);
    sb.delete();
    tick();
    rst = 1'b1;
    s0 = starts;
    repeat (100) tick();
    chk("arst_no_start", 32'(starts - s0), 0);
    chk("arst_still_empty", 32'(empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
